// File: rtl/argmax_classifier_if.sv
// rtl/argmax_classifier_if.sv - score-in / result-out handshake bundle for argmax_classifier
//
// Purpose: groups the input score stream and the output result handshake.
// Ports (signals):
//   in_valid/in_ready/in_data/in_last : one signed score per accepted beat
//   out_valid/out_ready               : result handshake
//   out_class/out_score/out_err       : winning index, its score, length error
// Modports: master = score producer / result consumer, slave = classifier.
interface argmax_classifier_if #(
  parameter int N     = 16,
  parameter int IDX_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_class;
  logic [N-1:0]     out_score;
  logic             out_err;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_class, out_score, out_err
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_class, out_score, out_err
  );
endinterface

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - streaming signed arg-max over one frame of class scores
//
// Purpose: tracks the running maximum of a frame of signed scores (strictly
// greater replaces, so ties keep the lowest index) and presents the winning
// index and score until the consumer takes it. A frame closes on in_last or
// after NUM_CLASSES scores, whichever comes first; out_err flags a mismatch.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : argmax_classifier_if.slave (score stream in, result handshake out)
module argmax_classifier #(
  parameter int N           = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  argmax_classifier_if.slave  bus
);

  typedef enum logic [1:0] {S_FIRST, S_ACCUM, S_HOLD} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                  state;
  logic [IDX_W-1:0]        cnt;
  logic [IDX_W-1:0]        max_idx;
  logic signed [N-1:0]     max_val;

  logic                    out_valid_q;
  logic [IDX_W-1:0]        out_class_q;
  logic [N-1:0]            out_score_q;
  logic                    out_err_q;

  logic                    accept;
  logic                    replace;
  logic                    frame_end;
  logic [IDX_W-1:0]        beat_idx;
  logic [IDX_W-1:0]        nxt_idx;
  logic signed [N-1:0]     nxt_max;

  assign bus.in_ready  = (state != S_HOLD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_score = out_score_q;
  assign bus.out_err   = out_err_q;

  // Post-compare view of the current beat; the final beat of a frame uses
  // these same values to load the result registers.
  always_comb begin
    accept    = bus.in_valid && bus.in_ready;
    beat_idx  = (state == S_FIRST) ? '0 : cnt;
    replace   = (state == S_FIRST) || ($signed(bus.in_data) > max_val);
    nxt_max   = replace ? $signed(bus.in_data) : max_val;
    nxt_idx   = replace ? beat_idx : max_idx;
    frame_end = bus.in_last || (beat_idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FIRST;
      cnt         <= '0;
      max_idx     <= '0;
      max_val     <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state)
        S_FIRST, S_ACCUM: begin
          if (accept) begin
            max_val <= nxt_max;
            max_idx <= nxt_idx;
            if (frame_end) begin
              // cnt is left alone here so it never has to hold NUM_CLASSES
              out_valid_q <= 1'b1;
              out_class_q <= nxt_idx;
              out_score_q <= nxt_max;
              out_err_q   <= bus.in_last ^ (beat_idx == LAST_IDX);
              state       <= S_HOLD;
            end else begin
              cnt   <= beat_idx + IDX_W'(1);
              state <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            cnt         <= '0;
            state       <= S_FIRST;
          end
        end
        default: state <= S_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - randomized self-checking bench for argmax_classifier
module tb_argmax_classifier;
  localparam int N           = 16;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  argmax_classifier_if #(.N(N), .IDX_W(IDX_W)) bus ();

  argmax_classifier #(.N(N), .NUM_CLASSES(NUM_CLASSES), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic signed [N-1:0] scores [0:15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives scores[0..] until the frame closes (in_last at last_at, or the
  // NUM_CLASSES-th score). Returns with the last beat just accepted.
  task automatic send_beats(input int last_at, input bit gaps, input int stop_after);
    int e;
    e = (last_at >= 0 && last_at < NUM_CLASSES - 1) ? last_at : NUM_CLASSES - 1;
    if (stop_after >= 0 && stop_after < e) e = stop_after;
    for (int i = 0; i <= e; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_data  = N'($urandom);
          bus.in_last  = 1'($urandom);
          step();
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = scores[i];
      bus.in_last  = (i == last_at);
      check("in_ready_beat", {31'b0, bus.in_ready}, 32'd1);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_frame(input int last_at, input bit gaps, input int hold);
    int e;
    logic signed [N-1:0] best;
    int bi;
    bit exp_err;
    e = (last_at >= 0 && last_at < NUM_CLASSES - 1) ? last_at : NUM_CLASSES - 1;
    best = scores[0];
    bi   = 0;
    for (int i = 1; i <= e; i++)
      if (scores[i] > best) begin
        best = scores[i];
        bi   = i;
      end
    exp_err = (last_at == e) != (e == NUM_CLASSES - 1);

    send_beats(last_at, gaps, -1);
    check("out_valid_rise", {31'b0, bus.out_valid}, 32'd1);
    check("in_ready_hold", {31'b0, bus.in_ready}, 32'd0);
    check("out_class", {28'b0, bus.out_class}, 32'(bi));
    check("out_score", {16'b0, bus.out_score}, {16'b0, best});
    check("out_err", {31'b0, bus.out_err}, {31'b0, exp_err});

    if (hold > 0) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h7fff;
      bus.in_last   = 1'b0;
      repeat (hold) begin
        step();
        check("bp_valid", {31'b0, bus.out_valid}, 32'd1);
        check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("bp_class", {28'b0, bus.out_class}, 32'(bi));
        check("bp_score", {16'b0, bus.out_score}, {16'b0, best});
      end
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
    end else begin
      step();
    end
    check("out_valid_drop", {31'b0, bus.out_valid}, 32'd0);
    check("in_ready_back", {31'b0, bus.in_ready}, 32'd1);
  endtask

  task automatic load(input int v0, input int v1, input int v2, input int v3, input int v4,
                      input int v5, input int v6, input int v7, input int v8, input int v9);
    scores[0] = N'(v0); scores[1] = N'(v1); scores[2] = N'(v2); scores[3] = N'(v3);
    scores[4] = N'(v4); scores[5] = N'(v5); scores[6] = N'(v6); scores[7] = N'(v7);
    scores[8] = N'(v8); scores[9] = N'(v9);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) scores[i] = '0;

    #3;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_class", {28'b0, bus.out_class}, 32'd0);
    check("rst_out_score", {16'b0, bus.out_score}, 32'd0);
    check("rst_out_err", {31'b0, bus.out_err}, 32'd0);
    #9 rst_n = 1'b1;
    step();

    load(3, -7, 12, 5, 12, 0, -1, 4, 2, 9);
    run_frame(9, 1'b0, 0);

    load(-100, -3, -50, -3, -32768, -9, -8, -7, -6, -5);
    run_frame(9, 1'b0, 0);

    load(1, 2, 8, 4, 0, 0, 0, 0, 0, 0);
    run_frame(3, 1'b0, 0);

    load(5, 6, 7, 1, 2, 3, 4, 5, 6, 7);
    run_frame(-1, 1'b0, 0);

    // result held under backpressure with a 32767 beat waiting, then frame 2
    load(-1, -2, -3, -4, -5, -6, -7, -8, -9, -10);
    run_frame(9, 1'b0, 5);
    load(10, 20, 30, 40, 50, 60, 70, 80, 90, 100);
    run_frame(9, 1'b0, 0);

    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      scores[i] = 16'sh7fff;
        else if (r == 1) scores[i] = 16'sh8000;
        else if (r < 5)  scores[i] = N'(int'($urandom_range(0, 6)) - 3);
        else             scores[i] = N'($urandom);
      end
      run_frame(($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 8)) : 9, 1'b1, 0);
    end

    // reset mid-frame after beat 4
    load(7, 7, 7, 7, 7, 7, 7, 7, 7, 7);
    send_beats(9, 1'b0, 4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("mid_rst_out_class", {28'b0, bus.out_class}, 32'd0);
    #3 rst_n = 1'b1;
    step();
    load(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_frame(9, 1'b0, 0);

    // reset while a result is held
    load(1, 9, 3, 4, 5, 6, 7, 8, 2, 0);
    send_beats(9, 1'b0, -1);
    check("pre_rst_hold", {31'b0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("hold_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("hold_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("hold_rst_out_score", {16'b0, bus.out_score}, 32'd0);
    #3 rst_n = 1'b1;
    step();
    load(-4, -4, -2, -2, -9, -1, -1, -30, 0, -5);
    run_frame(9, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
